// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel kernel: two line buffers plus
// per-row column history build the neighbourhood, held in a one-entry output register.
`timescale 1ns/1ps
module sobel_window_gen #(
    parameter int IMG_W = 352,
    parameter int IMG_H = 288
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_pixel,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [8:0]                 s11,
    output logic [8:0]                 s12,
    output logic [8:0]                 s13,
    output logic [8:0]                 s21,
    output logic [8:0]                 s22,
    output logic [8:0]                 s23,
    output logic [8:0]                 s31,
    output logic [8:0]                 s32,
    output logic [8:0]                 s33,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       win_last
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [7:0]    lb1_rd, lb2_rd;
    // Two older columns per row; the newest column comes live from the
    // line-buffer reads and in_pixel, so the window is ready on the transfer edge.
    logic [7:0]    top_h [2];
    logic [7:0]    mid_h [2];
    logic [7:0]    bot_h [2];
    logic          xfer, issue, col_last, row_last;

    assign in_ready = !win_valid || win_ready;
    assign xfer     = in_valid && in_ready;
    assign lb1_rd   = lb1[col];
    assign lb2_rd   = lb2[col];
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign issue    = xfer && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (xfer) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            lb2[col] <= lb1_rd;
            lb1[col] <= in_pixel;
            top_h[0] <= top_h[1];
            top_h[1] <= lb2_rd;
            mid_h[0] <= mid_h[1];
            mid_h[1] <= lb1_rd;
            bot_h[0] <= bot_h[1];
            bot_h[1] <= in_pixel;
        end
    end

    // A load wins over a drain, so simultaneous load+drain keeps win_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            s11 <= '0; s12 <= '0; s13 <= '0;
            s21 <= '0; s22 <= '0; s23 <= '0;
            s31 <= '0; s32 <= '0; s33 <= '0;
        end else if (issue) begin
            win_valid <= 1'b1;
            win_last  <= row_last && col_last;
            win_row   <= row - RW'(1);
            win_col   <= col - CW'(1);
            s11 <= {1'b0, top_h[0]}; s12 <= {1'b0, top_h[1]}; s13 <= {1'b0, lb2_rd};
            s21 <= {1'b0, mid_h[0]}; s22 <= {1'b0, mid_h[1]}; s23 <= {1'b0, lb1_rd};
            s31 <= {1'b0, bot_h[0]}; s32 <= {1'b0, bot_h[1]}; s33 <= {1'b0, in_pixel};
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a small 4x3 instance for directed cases and a larger
// instance for random traffic, both scored against a frame-image reference model.
`timescale 1ns/1ps
module tb_sobel_window_gen;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int BW = 24;
    localparam int BH = 10;
    localparam int PW = 114;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, win_ready;
    logic [7:0] in_pixel;
    int act;

    always #5 clk = ~clk;

    logic       s_in_ready, s_win_valid, s_win_last;
    logic [8:0] sw [9];
    logic [1:0] s_row, s_col;
    logic       b_in_ready, b_win_valid, b_win_last;
    logic [8:0] bw [9];
    logic [3:0] b_row;
    logic [4:0] b_col;

    sobel_window_gen #(.IMG_W(SW), .IMG_H(SH)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && (act == 0)), .in_ready(s_in_ready), .in_pixel(in_pixel),
        .win_valid(s_win_valid), .win_ready((act == 0) ? win_ready : 1'b1),
        .s11(sw[0]), .s12(sw[1]), .s13(sw[2]), .s21(sw[3]), .s22(sw[4]),
        .s23(sw[5]), .s31(sw[6]), .s32(sw[7]), .s33(sw[8]),
        .win_row(s_row), .win_col(s_col), .win_last(s_win_last)
    );

    sobel_window_gen #(.IMG_W(BW), .IMG_H(BH)) dut_big (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && (act == 1)), .in_ready(b_in_ready), .in_pixel(in_pixel),
        .win_valid(b_win_valid), .win_ready((act == 1) ? win_ready : 1'b1),
        .s11(bw[0]), .s12(bw[1]), .s13(bw[2]), .s21(bw[3]), .s22(bw[4]),
        .s23(bw[5]), .s31(bw[6]), .s32(bw[7]), .s33(bw[8]),
        .win_row(b_row), .win_col(b_col), .win_last(b_win_last)
    );

    logic          cur_in_ready, cur_valid;
    logic [PW-1:0] cur_pack;

    always_comb begin
        cur_pack = '0;
        for (int i = 0; i < 9; i++)
            cur_pack[PW-1-9*i -: 9] = (act == 0) ? sw[i] : bw[i];
        cur_pack[32:17] = (act == 0) ? 16'(s_row) : 16'(b_row);
        cur_pack[16:1]  = (act == 0) ? 16'(s_col) : 16'(b_col);
        cur_pack[0]     = (act == 0) ? s_win_last : b_win_last;
        cur_in_ready    = (act == 0) ? s_in_ready : b_in_ready;
        cur_valid       = (act == 0) ? s_win_valid : b_win_valid;
    end

    // Scoreboard state and reference model: the model keeps the current frame as an image.
    logic [PW-1:0] exp_q[$];
    logic [7:0]    img [0:1023];
    int cur_w, cur_h, m_row, m_col;
    int ntests = 0, nfail = 0;
    int win_cnt, last_cnt, stall_cycles, stall_cnt;
    bit rnd_ready, stall_arm, force_low, hold_prev;
    logic [PW-1:0] held;

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        ntests++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [PW-1:0] exp_window(input int r, input int c);
        logic [PW-1:0] v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[PW-1-9*(3*i+j) -: 9] = {1'b0, img[(r-2+i)*cur_w + (c-2+j)]};
        v[32:17] = 16'(r - 1);
        v[16:1]  = 16'(c - 1);
        v[0]     = (r == cur_h - 1) && (c == cur_w - 1);
        return v;
    endfunction

    task automatic model_accept(input logic [7:0] px);
        img[m_row*cur_w + m_col] = px;
        if (m_row >= 2 && m_col >= 2) exp_q.push_back(exp_window(m_row, m_col));
        if (m_col == cur_w - 1) begin
            m_col = 0;
            m_row = (m_row == cur_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    // Frame k of one call gets base + 100*k + 16*row + col (or random pixels).
    task automatic send_pixels(input int n, input int base, input bit rnd_pix, input bit rnd_valid);
        for (int k = 0; k < n; k++) begin
            logic [7:0] px;
            int waited;
            bit done;
            px = rnd_pix ? 8'($urandom) : 8'(base + 100*(k / (cur_w*cur_h)) + 16*m_row + m_col);
            waited = 0;
            done = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_pixel = px;
                @(negedge clk);
                if (in_valid && cur_in_ready) begin
                    model_accept(px);
                    done = 1'b1;
                end else if (++waited > 200) begin
                    check_int("input_accept_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bool_loop: for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && !cur_valid) return;
        end
        check_int({name, "_drain_timeout"}, exp_q.size(), 0);
    endtask

    // Consumer side: drives win_ready and compares every accepted window.
    always @(posedge clk) begin
        #1;
        if (stall_arm && cur_valid) begin
            stall_arm = 1'b0;
            stall_cnt = 5;
        end
        if (force_low) win_ready = 1'b0;
        else if (stall_cnt > 0) begin
            win_ready = 1'b0;
            stall_cnt--;
        end else win_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (reset) hold_prev = 1'b0;
        else begin
            if (hold_prev) check("hold_stable", cur_pack, held);
            if (cur_valid && !win_ready) begin
                stall_cycles++;
                check("stall_in_ready", PW'(cur_in_ready), PW'(0));
            end
            if (cur_valid && win_ready) begin
                if (exp_q.size() == 0) check("unexpected_window", cur_pack, '0);
                else check("window", cur_pack, exp_q.pop_front());
                win_cnt++;
                if (cur_pack[0]) last_cnt++;
            end
            hold_prev = cur_valid && !win_ready;
            held = cur_pack;
        end
    end

    initial begin
        act = 0; reset = 1'b1; in_valid = 1'b0; in_pixel = '0; win_ready = 1'b0;
        rnd_ready = 1'b0; stall_arm = 1'b0; stall_cnt = 0; force_low = 1'b1;
        cur_w = SW; cur_h = SH; m_row = 0; m_col = 0;
        win_cnt = 0; last_cnt = 0; stall_cycles = 0; hold_prev = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", cur_pack, '0);
        check("reset_valid", PW'(cur_valid), PW'(0));
        check("reset_in_ready", PW'(cur_in_ready), PW'(1));
        reset = 1'b0;
        force_low = 1'b0;

        // Small frame, pixel = 16*row + col
        win_cnt = 0; last_cnt = 0;
        send_pixels(SW*SH, 0, 1'b0, 1'b0);
        drain("small");
        check_int("small_count", win_cnt, 2);
        check_int("small_last", last_cnt, 1);

        // Backpressure after the first window
        win_cnt = 0; last_cnt = 0; stall_cycles = 0; stall_arm = 1'b1;
        send_pixels(SW*SH, 0, 1'b0, 1'b0);
        drain("bp");
        check_int("bp_count", win_cnt, 2);
        check_int("bp_stall_cycles", stall_cycles, 5);

        // Two frames back to back, second frame offset by 100
        win_cnt = 0; last_cnt = 0;
        send_pixels(2*SW*SH, 0, 1'b0, 1'b0);
        drain("b2b");
        check_int("b2b_count", win_cnt, 4);
        check_int("b2b_last", last_cnt, 2);

        // Reset after 7 pixels, then a fresh frame
        win_cnt = 0; last_cnt = 0;
        send_pixels(7, 0, 1'b0, 1'b0);
        force_low = 1'b1;
        @(posedge clk); #2;
        win_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_outputs", cur_pack, '0);
        check("midreset_valid", PW'(cur_valid), PW'(0));
        check("midreset_in_ready", PW'(cur_in_ready), PW'(1));
        m_row = 0; m_col = 0;
        #3;
        reset = 1'b0;
        force_low = 1'b0;
        send_pixels(SW*SH, 0, 1'b0, 1'b0);
        drain("midreset");
        check_int("midreset_count", win_cnt, 2);
        check_int("midreset_last", last_cnt, 1);

        // Random traffic on the larger image, two frames
        act = 1; cur_w = BW; cur_h = BH; m_row = 0; m_col = 0;
        rnd_ready = 1'b1; win_cnt = 0; last_cnt = 0;
        send_pixels(2*BW*BH, 0, 1'b1, 1'b1);
        drain("random");
        check_int("random_count", win_cnt, 2*(BW-2)*(BH-2));
        check_int("random_last", last_cnt, 2);
        check_int("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
